// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding selects (registered, valid one cycle after ID) and
// load-use stall/bubble generation; a detected load-use holds the pipe for LOAD_USE_CYCLES cycles.
module fwd_hazard_unit #(
   parameter int ADDR_W          = 5,
   parameter int NUM_SRC         = 2,
   parameter int LOAD_USE_CYCLES = 1
) (
   input  logic                      CLK,
   input  logic                      RESET,
   input  logic [NUM_SRC*ADDR_W-1:0] ID_RS_ADDR,
   input  logic [NUM_SRC-1:0]        ID_RS_USED,
   input  logic [ADDR_W-1:0]         EX_RD_ADDR,
   input  logic                      EX_WE,
   input  logic                      EX_IS_LOAD,
   input  logic [ADDR_W-1:0]         MEM_RD_ADDR,
   input  logic                      MEM_WE,
   output logic [2*NUM_SRC-1:0]      FWD_SEL,
   output logic                      STALL,
   output logic                      BUBBLE
);

   if (LOAD_USE_CYCLES < 1 || LOAD_USE_CYCLES > 7) begin : g_bad_load_use_cycles
      $error("fwd_hazard_unit: LOAD_USE_CYCLES must be in 1..7");
   end
   if (NUM_SRC < 1 || NUM_SRC > 3) begin : g_bad_num_src
      $error("fwd_hazard_unit: NUM_SRC must be in 1..3");
   end

   typedef enum logic {
      S_IDLE,
      S_STALL_CNT
   } state_t;

   localparam logic [2:0] CNT_LOAD = 3'(LOAD_USE_CYCLES - 1);

   state_t               state, state_nxt;
   logic [2:0]           cnt, cnt_nxt;
   logic [NUM_SRC-1:0]   ex_match;
   logic [NUM_SRC-1:0]   mem_match;
   logic [2*NUM_SRC-1:0] next_sel;
   logic                 hz;
   logic                 stall_int;

   // Nearest producer wins: an EX hit is forwarded from MEM next cycle, a MEM hit from WB.
   always_comb begin
      ex_match  = '0;
      mem_match = '0;
      next_sel  = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         ex_match[i]  = ID_RS_USED[i] & EX_WE
                        & (EX_RD_ADDR == ID_RS_ADDR[i*ADDR_W +: ADDR_W])
                        & (ID_RS_ADDR[i*ADDR_W +: ADDR_W] != '0);
         mem_match[i] = ID_RS_USED[i] & MEM_WE
                        & (MEM_RD_ADDR == ID_RS_ADDR[i*ADDR_W +: ADDR_W])
                        & (ID_RS_ADDR[i*ADDR_W +: ADDR_W] != '0);
         if (ex_match[i]) begin
            next_sel[2*i +: 2] = 2'b01;
         end else if (mem_match[i]) begin
            next_sel[2*i +: 2] = 2'b10;
         end
      end
   end

   assign hz = EX_IS_LOAD & (|ex_match);

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // The first stall cycle is spent in IDLE, so STALL_CNT only covers the remaining LOAD_USE_CYCLES-1.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         S_IDLE: begin
            if (hz && (LOAD_USE_CYCLES > 1)) begin
               state_nxt = S_STALL_CNT;
               cnt_nxt   = CNT_LOAD;
            end
         end
         S_STALL_CNT: begin
            if (cnt == 3'd1) begin
               state_nxt = S_IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt   = cnt - 3'd1;
            end
         end
         default: begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_comb begin
      stall_int = 1'b0;
      case (state)
         S_IDLE:      stall_int = hz;
         S_STALL_CNT: stall_int = 1'b1;
         default:     stall_int = 1'b0;
      endcase
      STALL  = RESET & stall_int;
      BUBBLE = RESET & stall_int;
   end

   // The bubble entering EX during a stall needs no forwarding.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         FWD_SEL <= '0;
      end else if (stall_int) begin
         FWD_SEL <= '0;
      end else begin
         FWD_SEL <= next_sel;
      end
   end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Three parameterisations of fwd_hazard_unit share one stimulus stream and are
// checked cycle by cycle against a remaining-stall-count reference model.
module tb_fwd_hazard_unit;

   logic        clk;
   logic        rst_n;
   logic [14:0] rs_addr;
   logic [2:0]  rs_used;
   logic [4:0]  ex_rd;
   logic        ex_we;
   logic        ex_ld;
   logic [4:0]  mem_rd;
   logic        mem_we;

   logic [3:0]  sel_a, sel_b;
   logic [5:0]  sel_c;
   logic        stall_a, stall_b, stall_c;
   logic        bubble_a, bubble_b, bubble_c;

   int tests_run    = 0;
   int tests_failed = 0;

   int         luc_m[3]  = '{1, 3, 2};
   int         nsrc_m[3] = '{2, 2, 3};
   int         rem[3];
   logic [5:0] msel[3];

   fwd_hazard_unit #(.ADDR_W(5), .NUM_SRC(2), .LOAD_USE_CYCLES(1)) u_dut_a (
      .CLK(clk), .RESET(rst_n),
      .ID_RS_ADDR(rs_addr[9:0]), .ID_RS_USED(rs_used[1:0]),
      .EX_RD_ADDR(ex_rd), .EX_WE(ex_we), .EX_IS_LOAD(ex_ld),
      .MEM_RD_ADDR(mem_rd), .MEM_WE(mem_we),
      .FWD_SEL(sel_a), .STALL(stall_a), .BUBBLE(bubble_a)
   );

   fwd_hazard_unit #(.ADDR_W(5), .NUM_SRC(2), .LOAD_USE_CYCLES(3)) u_dut_b (
      .CLK(clk), .RESET(rst_n),
      .ID_RS_ADDR(rs_addr[9:0]), .ID_RS_USED(rs_used[1:0]),
      .EX_RD_ADDR(ex_rd), .EX_WE(ex_we), .EX_IS_LOAD(ex_ld),
      .MEM_RD_ADDR(mem_rd), .MEM_WE(mem_we),
      .FWD_SEL(sel_b), .STALL(stall_b), .BUBBLE(bubble_b)
   );

   fwd_hazard_unit #(.ADDR_W(5), .NUM_SRC(3), .LOAD_USE_CYCLES(2)) u_dut_c (
      .CLK(clk), .RESET(rst_n),
      .ID_RS_ADDR(rs_addr), .ID_RS_USED(rs_used),
      .EX_RD_ADDR(ex_rd), .EX_WE(ex_we), .EX_IS_LOAD(ex_ld),
      .MEM_RD_ADDR(mem_rd), .MEM_WE(mem_we),
      .FWD_SEL(sel_c), .STALL(stall_c), .BUBBLE(bubble_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Spec-level view: what each operand wants, and whether a load in EX feeds any of them.
   function automatic void eval(input int d, output logic [5:0] ns, output bit hz);
      int rs;
      int code;
      ns = '0;
      hz = 1'b0;
      for (int i = 0; i < nsrc_m[d]; i++) begin
         rs   = int'(rs_addr >> (5 * i)) & 31;
         code = 0;
         if (rs_used[i] && rs != 0) begin
            if (ex_we && int'(ex_rd) == rs) begin
               code = 1;
               if (ex_ld) hz = 1'b1;
            end else if (mem_we && int'(mem_rd) == rs) begin
               code = 2;
            end
         end
         ns = ns | 6'(code << (2 * i));
      end
   endfunction

   function automatic bit model_stall(input int d);
      logic [5:0] ns;
      bit         hz;
      eval(d, ns, hz);
      return rst_n && (rem[d] > 0 || hz);
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 3; d++) begin
         rem[d]  = 0;
         msel[d] = '0;
      end
   endtask

   task automatic model_clock();
      logic [5:0] ns;
      bit         hz;
      bit         st;
      for (int d = 0; d < 3; d++) begin
         eval(d, ns, hz);
         st      = (rem[d] > 0) || hz;
         msel[d] = st ? 6'd0 : ns;
         if (rem[d] > 0) rem[d] = rem[d] - 1;
         else if (hz)    rem[d] = luc_m[d] - 1;
      end
   endtask

   task automatic compare_all();
      chk("a_stall",  stall_a,  model_stall(0));
      chk("a_bubble", bubble_a, model_stall(0));
      chk("a_sel",    sel_a,    msel[0]);
      chk("b_stall",  stall_b,  model_stall(1));
      chk("b_bubble", bubble_b, model_stall(1));
      chk("b_sel",    sel_b,    msel[1]);
      chk("c_stall",  stall_c,  model_stall(2));
      chk("c_bubble", bubble_c, model_stall(2));
      chk("c_sel",    sel_c,    msel[2]);
   endtask

   // Called just after a negedge with inputs applied; returns at the following negedge.
   task automatic step();
      #1;
      compare_all();
      @(posedge clk);
      if (rst_n) model_clock();
      @(negedge clk);
   endtask

   task automatic set_in(input int r1, input int r2, input int r3, input logic [2:0] used,
                         input int erd, input logic ewe, input logic eld,
                         input int mrd, input logic mwe);
      rs_addr = {5'(r3), 5'(r2), 5'(r1)};
      rs_used = used;
      ex_rd   = 5'(erd);
      ex_we   = ewe;
      ex_ld   = eld;
      mem_rd  = 5'(mrd);
      mem_we  = mwe;
   endtask

   task automatic idle(input int n);
      set_in(0, 0, 0, 3'b000, 0, 1'b0, 1'b0, 0, 1'b0);
      for (int k = 0; k < n; k++) step();
   endtask

   initial begin
      logic s1, s2, s3, s4;
      model_reset();
      rst_n = 1'b0;
      set_in(0, 0, 0, 3'b000, 0, 1'b0, 1'b0, 0, 1'b0);
      #1;
      chk("rst_sel_a", sel_a, 0);
      chk("rst_sel_c", sel_c, 0);
      chk("rst_stall_b", stall_b, 0);
      // Hazard-looking inputs while reset is held must not raise STALL.
      set_in(9, 0, 0, 3'b001, 9, 1'b1, 1'b1, 0, 1'b0);
      #1;
      chk("rst_hold_stall_a", stall_a, 0);
      chk("rst_hold_bubble_c", bubble_c, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      // EX priority over MEM, then MEM alone.
      set_in(5, 0, 0, 3'b001, 5, 1'b1, 1'b0, 5, 1'b1);
      step();
      chk("t2_ex_priority", sel_a[1:0], 2'b01);
      chk("t2_no_stall", stall_a, 0);
      set_in(5, 0, 0, 3'b001, 5, 1'b0, 1'b0, 5, 1'b1);
      step();
      chk("t2_mem_fwd", sel_a[1:0], 2'b10);

      // x0 never matches; an unused operand never forwards nor stalls.
      set_in(0, 0, 0, 3'b010, 0, 1'b1, 1'b0, 0, 1'b1);
      step();
      chk("t3_x0", sel_a[3:2], 2'b00);
      set_in(7, 0, 0, 3'b000, 7, 1'b1, 1'b1, 0, 1'b0);
      #1;
      chk("t3_unused_stall", stall_a, 0);
      step();
      chk("t3_unused_sel", sel_a[1:0], 2'b00);

      // Single-cycle load-use, then the load has reached MEM.
      set_in(0, 9, 0, 3'b010, 9, 1'b1, 1'b1, 0, 1'b0);
      #1;
      chk("t4_stall", stall_a, 1);
      chk("t4_bubble", bubble_a, 1);
      step();
      chk("t4_sel_suppressed", sel_a, 0);
      set_in(0, 9, 0, 3'b010, 0, 1'b0, 1'b0, 9, 1'b1);
      #1;
      chk("t4_stall_released", stall_a, 0);
      step();
      chk("t4_wb_fwd", sel_a[3:2], 2'b10);
      idle(4);

      // Three-cycle stall; a second load during the stall is ignored.
      set_in(0, 9, 0, 3'b010, 9, 1'b1, 1'b1, 0, 1'b0);
      #1 s1 = stall_b;
      step();
      set_in(9, 9, 0, 3'b011, 9, 1'b1, 1'b1, 0, 1'b0);
      #1 s2 = stall_b;
      step();
      #1 s3 = stall_b;
      step();
      set_in(0, 9, 0, 3'b010, 0, 1'b0, 1'b0, 0, 1'b0);
      #1 s4 = stall_b;
      step();
      chk("t5_stall_run", {s1, s2, s3, s4}, 4'b1110);
      chk("t5_sel_after", sel_b, 0);
      idle(4);

      // Three operands: rs1 from EX, rs3 from MEM, rs2 unmatched.
      set_in(3, 20, 12, 3'b111, 3, 1'b1, 1'b0, 12, 1'b1);
      step();
      chk("t6_sel3", sel_c, 6'b100001);
      set_in(3, 20, 12, 3'b100, 12, 1'b1, 1'b1, 0, 1'b0);
      #1;
      chk("t6_rs3_load_stall", stall_c, 1);
      step();
      idle(4);

      // Asynchronous reset in the middle of a 3-cycle stall (counter = 2).
      set_in(0, 9, 0, 3'b010, 9, 1'b1, 1'b1, 0, 1'b0);
      step();
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("t1_stall_b", stall_b, 0);
      chk("t1_bubble_b", bubble_b, 0);
      chk("t1_sel_b", sel_b, 0);
      compare_all();
      @(posedge clk);
      #1;
      compare_all();
      @(negedge clk);
      rst_n = 1'b1;
      set_in(0, 9, 0, 3'b010, 9, 1'b1, 1'b1, 0, 1'b0);
      #1 s1 = stall_b;
      step();
      set_in(0, 0, 0, 3'b000, 0, 1'b0, 1'b0, 0, 1'b0);
      #1 s2 = stall_b;
      step();
      #1 s3 = stall_b;
      step();
      #1 s4 = stall_b;
      step();
      chk("t1_full_stall_after_reset", {s1, s2, s3, s4}, 4'b1110);

      // Random traffic on a small register range so matches and hazards are frequent.
      for (int n = 0; n < 400; n++) begin
         set_in($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                3'($urandom_range(0, 7)), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                $urandom_range(0, 3), 1'($urandom_range(0, 1)));
         step();
      end

      // Reset must clear a live, non-zero select immediately.
      idle(4);
      set_in(5, 6, 0, 3'b011, 5, 1'b1, 1'b0, 6, 1'b1);
      step();
      chk("rst_live_sel_pre", sel_a, 4'b1001);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("rst_live_sel_a", sel_a, 0);
      compare_all();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the two-operand ALU forwarding detector.
- Compares NUM_SRC ID-stage source addresses against the destinations of the instructions in the ALU (EX) and MEM stages.
- Registers per-operand forward selects into the EX stage and detects load-use hazards.
- Load-use hazards are handled with a counted stall/bubble state machine.
- Sits between the ID/EX pipeline register and the EX operand muxes.

Parameters:
- ADDR_W, 5, register address width.
- NUM_SRC, 2, number of source operands checked (rs1, rs2, optional rs3).
- LOAD_USE_CYCLES, 1, stall cycles inserted per load-use hazard (1..7).

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  asynchronous, active-low reset.
- ID_RS_ADDR  in  NUM_SRC*ADDR_W  ID-stage source addresses; operand i at bits [i*ADDR_W +: ADDR_W].
- ID_RS_USED  in  NUM_SRC  operand i is actually read by the ID instruction.
- EX_RD_ADDR  in  ADDR_W  destination of the instruction in the ALU stage.
- EX_WE  in  1  ALU-stage instruction writes the register file.
- EX_IS_LOAD  in  1  ALU-stage instruction is a load.
- MEM_RD_ADDR  in  ADDR_W  destination of the instruction in the MEM stage.
- MEM_WE  in  1  MEM-stage instruction writes the register file.
- FWD_SEL  out  2*NUM_SRC  registered per-operand select; 00 = regfile, 01 = from MEM stage, 10 = from WB stage, 11 unused.
- STALL  out  1  freeze PC and the IF/ID register.
- BUBBLE  out  1  load a NOP into ID/EX at the next edge.

Behaviour:
- Reset (RESET=0, asynchronous):
  - FWD_SEL = 0, state = IDLE, counter = 0.
  - STALL = 0 and BUBBLE = 0 while reset is held.
  - Reset mid-stall aborts the stall immediately.
- Match qualification, per operand i:
  - EX match = ID_RS_USED[i] & EX_WE & (EX_RD_ADDR == rs_i) & (rs_i != 0).
  - MEM match is the same, using MEM_WE / MEM_RD_ADDR.
  - Address 0 never matches.
- Forward select (next_sel):
  - EX match → 01: the value will be in the MEM stage next cycle.
  - Else MEM match → 10.
  - Else 00.
  - The nearest stage wins when both match.
- FWD_SEL register: at posedge, FWD_SEL <= next_sel when STALL=0; FWD_SEL <= 0 when STALL=1, because the bubble entering EX needs no forwarding.
- Latency: select computed in cycle t (ID) is valid throughout cycle t+1 (EX).
- Load-use hazard: hz = EX_IS_LOAD & (any operand EX match).
- FSM:
  - IDLE: STALL = BUBBLE = hz (combinational).
  - IDLE → STALL_CNT on hz when LOAD_USE_CYCLES > 1, counter loaded with LOAD_USE_CYCLES-1.
  - IDLE stays IDLE when LOAD_USE_CYCLES = 1, because the stall completes in one cycle.
  - STALL_CNT: STALL = BUBBLE = 1 and inputs are ignored for new hazard detection. Counter decrements each posedge; when it reaches 1, the next state is IDLE.
  - Total stall length is exactly LOAD_USE_CYCLES cycles per hazard.
- After the stall releases, re-evaluation in IDLE uses the current EX/MEM inputs:
  - With LOAD_USE_CYCLES=1, the load sits in MEM, so the select becomes 10 (forward from WB).
  - With larger LOAD_USE_CYCLES, the load has left MEM; the select becomes 00 and the write-first register file supplies the value.
- Simultaneous events:
  - A load hazard on one operand and an ALU forward on another still stall; the FWD_SEL update is suppressed during the stall.
  - A non-load EX match never stalls.
- Width rules:
  - NUM_SRC = 1..3.
  - Counter width is 3 bits.
  - LOAD_USE_CYCLES = 0 is illegal; the implementation must flag it with an elaboration-time error.

Test Plan:
1. Reset low mid-stall (LOAD_USE_CYCLES=3, counter=2) → STALL, BUBBLE and FWD_SEL all 0 immediately, without waiting for CLK. After release, the next hazard stalls a full 3 cycles.
2. rs1=5 used, EX_RD=5 EX_WE=1 non-load, MEM_RD=5 MEM_WE=1 → next cycle FWD_SEL[1:0]=01 (EX priority), no stall. Same with EX_WE=0 → 10.
3. rs2=0 used, EX_RD=0 EX_WE=1 → FWD_SEL[3:2]=00. rs1=7 with ID_RS_USED[0]=0 and EX match → 00, no stall.
4. LOAD_USE_CYCLES=1: EX load to x9, rs2=9 used → STALL=BUBBLE=1 for exactly 1 cycle and FWD_SEL=0 at the next edge. Then, with x9 in MEM, FWD_SEL[3:2]=10.
5. LOAD_USE_CYCLES=3, same load → STALL high for exactly 3 consecutive cycles. A second matching load presented during the stall is ignored. After release FWD_SEL=00.
6. NUM_SRC=3: rs3=12 matches MEM only while rs1 matches EX → FWD_SEL = {10,00,01}. Then an EX load on rs3 → stall.
